slicer_bank_cal: RTL and testbench

Parametrised N-channel clocked-slicer controller with per-channel offset trim and on-demand foreground calibration. In mission mode it registers the decisions of NCH analog compare slicers. In calibration mode it shorts the slicer inputs and runs a majority-voted successive-approximation (SAR) search per channel to set a trim code that cancels slicer offset. The block sits between the xreal slicer bank (compare primitives driven by trig) and downstream digital logic.

---
 rtl/slicer_cal_pkg.sv | 23 ++
 rtl/slicer_sar_vote.sv | 49 ++++
 rtl/slicer_bank_cal.sv | 140 ++++++++++++++
 tb/tb_slicer_bank_cal.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/slicer_cal_pkg.sv
// Shared types and helpers for the slicer bank offset-calibration controller.
package slicer_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DECIDE,
    ST_NEXT_CH,
    ST_DONE
  } cal_state_t;

  // Midscale code (zero offset) for a trim word of width w.
  function automatic logic [31:0] trim_mid(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // One-hot trial bit for SAR step idx.
  function automatic logic [31:0] trial_bit(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/slicer_sar_vote.sv
// Per-bit SAR timing and majority vote: settle wait, sample accumulation, keep decision.
module slicer_sar_vote #(
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned SETTLE   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_settle,
  input  logic in_accum,
  input  logic in_decide,
  input  logic comp_bit,
  output logic settle_done,
  output logic accum_done,
  output logic keep
);

  localparam int unsigned NACC   = 1 << AVG_LOG2;
  localparam int unsigned CMAX   = (SETTLE > NACC) ? SETTLE : NACC;
  localparam int unsigned CNT_W  = $clog2(CMAX + 1);
  localparam int unsigned ONES_W = AVG_LOG2 + 1;

  logic [CNT_W-1:0]  cnt;
  logic [ONES_W-1:0] ones;

  assign settle_done = in_settle && (cnt == CNT_W'(SETTLE - 1));
  assign accum_done  = in_accum && (cnt == CNT_W'(NACC - 1));
  // A tie at exactly half the samples keeps the trial bit.
  assign keep        = (ones >= ONES_W'(NACC / 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      ones <= '0;
    end else begin
      if (in_settle) begin
        cnt <= settle_done ? '0 : cnt + 1'b1;
      end
      if (in_accum) begin
        cnt  <= accum_done ? '0 : cnt + 1'b1;
        ones <= ones + ONES_W'(comp_bit);
      end
      if (in_decide) begin
        cnt  <= '0;
        ones <= '0;
      end
    end
  end

endmodule

// File: rtl/slicer_bank_cal.sv
// N-channel slicer decision register with per-channel trim and foreground SAR offset calibration.
module slicer_bank_cal
  import slicer_cal_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned TRIM_W   = 6,
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned SETTLE   = 3,
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  trig,
  input  logic                  rst,
  input  logic [NCH-1:0]        comp,
  input  logic                  cal_start,
  input  logic                  trim_wr,
  input  logic [CH_W-1:0]       trim_waddr,
  input  logic [TRIM_W-1:0]     trim_wdata,
  output logic [NCH-1:0]        dout,
  output logic [NCH*TRIM_W-1:0] trim,
  output logic                  cal_short,
  output logic                  cal_busy,
  output logic                  cal_done,
  output logic [CH_W-1:0]       cal_ch
);

  localparam int unsigned BI_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MID = TRIM_W'(trim_mid(TRIM_W));

  cal_state_t        state, state_nx;
  logic [TRIM_W-1:0] trim_q [NCH];
  logic [BI_W-1:0]   bit_idx;
  logic [TRIM_W-1:0] trial;
  logic              cur_comp;
  logic              last_ch;
  logic              idle_like;
  logic              settle_done, accum_done, keep;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign cal_busy  = !idle_like;
  assign cal_short = !idle_like;
  assign cal_done  = (state == ST_DONE);
  assign last_ch   = (cal_ch == CH_W'(NCH - 1));
  assign trial     = TRIM_W'(trial_bit(32'(bit_idx)));

  always_comb begin
    cur_comp = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cal_ch == CH_W'(k)) cur_comp = comp[k];
    end
  end

  always_comb begin
    trim = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      trim[k*TRIM_W +: TRIM_W] = trim_q[k];
    end
  end

  slicer_sar_vote #(
    .AVG_LOG2 (AVG_LOG2),
    .SETTLE   (SETTLE)
  ) u_vote (
    .clk         (trig),
    .rst         (rst),
    .in_settle   (state == ST_SETTLE),
    .in_accum    (state == ST_ACCUM),
    .in_decide   (state == ST_DECIDE),
    .comp_bit    (cur_comp),
    .settle_done (settle_done),
    .accum_done  (accum_done),
    .keep        (keep)
  );

  always_ff @(posedge trig) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (cal_start) state_nx = ST_SETTLE;
      ST_SETTLE:        if (settle_done) state_nx = ST_ACCUM;
      ST_ACCUM:         if (accum_done) state_nx = ST_DECIDE;
      ST_DECIDE:        state_nx = (bit_idx != '0) ? ST_SETTLE : ST_NEXT_CH;
      ST_NEXT_CH:       state_nx = last_ch ? ST_DONE : ST_SETTLE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge trig) begin
    if (rst) begin
      cal_ch  <= '0;
      bit_idx <= '0;
    end else begin
      if (idle_like && cal_start) begin
        cal_ch  <= '0;
        bit_idx <= BI_W'(TRIM_W - 1);
      end else if (state == ST_DECIDE && bit_idx != '0) begin
        bit_idx <= bit_idx - 1'b1;
      end else if (state == ST_NEXT_CH && !last_ch) begin
        cal_ch  <= cal_ch + 1'b1;
        bit_idx <= BI_W'(TRIM_W - 1);
      end
    end
  end

  // DECIDE resolves the current trial bit and arms the next lower one in a single write.
  always_ff @(posedge trig) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCH; k++) trim_q[k] <= MID;
    end else if (idle_like) begin
      if (cal_start) begin
        trim_q[0] <= MID;
      end else if (trim_wr) begin
        for (int unsigned k = 0; k < NCH; k++) begin
          if (trim_waddr == CH_W'(k)) trim_q[k] <= trim_wdata;
        end
      end
    end else if (state == ST_DECIDE) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (cal_ch == CH_W'(k)) begin
          trim_q[k] <= (trim_q[k] & ~trial)
                     | (keep ? trial : '0)
                     | ((bit_idx != '0) ? (trial >> 1) : '0);
        end
      end
    end else if (state == ST_NEXT_CH && !last_ch) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if ((cal_ch + 1'b1) == CH_W'(k)) trim_q[k] <= MID;
      end
    end
  end

  always_ff @(posedge trig) begin
    if (rst)            dout <= '0;
    else if (!cal_busy) dout <= comp;
  end

endmodule

// File: tb/tb_slicer_bank_cal.sv
// Directed bench for slicer_bank_cal: vector table for mission mode and manual trim, sequences for calibration.
module tb_slicer_bank_cal;

  logic        trig = 1'b0;
  logic        rst;
  logic [3:0]  comp;
  logic        cal_start, trim_wr;
  logic [1:0]  trim_waddr;
  logic [5:0]  trim_wdata;
  logic [3:0]  dout;
  logic [23:0] trim;
  logic        cal_short, cal_busy, cal_done;
  logic [1:0]  cal_ch;

  logic [2:0]  comp2;
  logic        cal_start2, trim_wr2;
  logic [1:0]  trim_waddr2;
  logic [5:0]  trim_wdata2;
  logic [2:0]  dout2;
  logic [17:0] trim2;
  logic        cal_short2, cal_busy2, cal_done2;
  logic [1:0]  cal_ch2;

  int          errors = 0;
  int          checks = 0;
  int          mode = 0;
  int unsigned noise_ones = 8;
  int unsigned cyc = 0;
  logic [3:0]  comp_force;
  logic [5:0]  tgt [4] = '{6'd37, 6'd0, 6'd63, 6'd32};

  slicer_bank_cal u_dut (
    .trig(trig), .rst(rst), .comp(comp), .cal_start(cal_start),
    .trim_wr(trim_wr), .trim_waddr(trim_waddr), .trim_wdata(trim_wdata),
    .dout(dout), .trim(trim), .cal_short(cal_short), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_ch(cal_ch)
  );

  slicer_bank_cal #(.NCH(3)) u_dut3 (
    .trig(trig), .rst(rst), .comp(comp2), .cal_start(cal_start2),
    .trim_wr(trim_wr2), .trim_waddr(trim_waddr2), .trim_wdata(trim_wdata2),
    .dout(dout2), .trim(trim2), .cal_short(cal_short2), .cal_busy(cal_busy2),
    .cal_done(cal_done2), .cal_ch(cal_ch2)
  );

  initial forever #5 trig = ~trig;

  always @(posedge trig) cyc <= cyc + 1;

  // Offset model: shorted slicer reads 1 while the code is at or below its target.
  always_comb begin
    comp = comp_force;
    if (mode != 0) begin
      for (int k = 0; k < 4; k++) comp[k] = (trim[k*6 +: 6] <= tgt[k]);
      if (mode == 2) comp[0] = ((cyc % 16) < noise_ones);
    end
  end

  typedef struct {
    logic [3:0]  c;
    logic        wr;
    logic [1:0]  addr;
    logic [5:0]  data;
    logic [3:0]  exp_dout;
    logic [23:0] exp_trim;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [23:0] pk(input int t0, input int t1, input int t2, input int t3);
    return {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge trig);
    #1;
  endtask

  task automatic run_cal(input string name);
    int unsigned n;
    logic        short_ok;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    n = 0;
    short_ok = 1'b1;
    while (!cal_done && n < 600) begin
      if (!cal_short) short_ok = 1'b0;
      tick();
      n++;
    end
    chk({name, "_len"}, n, 484);
    chk({name, "_short"}, short_ok, 1);
  endtask

  initial begin
    int unsigned n;
    logic        short_ok;

    rst = 1'b1; comp_force = 4'b1111; cal_start = 1'b0; trim_wr = 1'b0;
    trim_waddr = '0; trim_wdata = '0;
    comp2 = 3'b101; cal_start2 = 1'b0; trim_wr2 = 1'b0; trim_waddr2 = '0; trim_wdata2 = '0;

    vecs[0] = '{4'b1010, 1'b0, 2'd0, 6'd0,  4'b1010, pk(32, 32, 32, 32)};
    vecs[1] = '{4'b0101, 1'b1, 2'd1, 6'd5,  4'b0101, pk(32, 5, 32, 32)};
    vecs[2] = '{4'b0000, 1'b1, 2'd3, 6'd63, 4'b0000, pk(32, 5, 32, 63)};
    vecs[3] = '{4'b1111, 1'b1, 2'd0, 6'd0,  4'b1111, pk(0, 5, 32, 63)};
    vecs[4] = '{4'b0110, 1'b0, 2'd2, 6'd9,  4'b0110, pk(0, 5, 32, 63)};

    tick(); tick();
    chk("rst_dout", dout, 0);
    chk("rst_trim", trim, pk(32, 32, 32, 32));
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_short", cal_short, 0);
    chk("rst_ch", cal_ch, 0);
    chk("rst_trim_n3", trim2, {6'd32, 6'd32, 6'd32});
    rst = 1'b0;
    tick();
    chk("rel_dout", dout, 4'b1111);
    chk("rel_dout_n3", dout2, 3'b101);

    for (int i = 0; i < 5; i++) begin
      comp_force = vecs[i].c;
      trim_wr    = vecs[i].wr;
      trim_waddr = vecs[i].addr;
      trim_wdata = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_trim", i), trim, vecs[i].exp_trim);
    end
    trim_wr = 1'b0;

    // Out-of-range and in-range manual writes on a 3-channel instance.
    trim_wr2 = 1'b1; trim_waddr2 = 2'd3; trim_wdata2 = 6'd7;
    tick();
    chk("n3_wr_oob", trim2, {6'd32, 6'd32, 6'd32});
    trim_waddr2 = 2'd2;
    tick();
    chk("n3_wr_ok", trim2, {6'd7, 6'd32, 6'd32});
    trim_wr2 = 1'b0;

    // Calibration with a colliding write, a write while busy and a re-pulsed start.
    mode = 1;
    cal_start = 1'b1; trim_wr = 1'b1; trim_waddr = 2'd2; trim_wdata = 6'd9;
    tick();
    cal_start = 1'b0; trim_wr = 1'b0;
    chk("start_trim", trim, pk(32, 5, 32, 63));
    chk("start_busy", cal_busy, 1);
    chk("start_short", cal_short, 1);
    chk("start_done", cal_done, 0);
    chk("start_ch", cal_ch, 0);
    chk("start_dout", dout, 4'b0101);
    n = 0;
    short_ok = 1'b1;
    while (!cal_done && n < 600) begin
      trim_wr    = (n == 10);
      trim_waddr = 2'd1;
      trim_wdata = 6'd17;
      cal_start  = (n == 100);
      if (!cal_short) short_ok = 1'b0;
      tick();
      n++;
      if (n == 11) begin
        chk("busy_wr_trim1", trim[11:6], 5);
        chk("idle_ch_trim3", trim[23:18], 63);
      end
      if (n == 50) chk("busy_dout_hold", dout, 4'b0101);
    end
    trim_wr = 1'b0; cal_start = 1'b0;
    chk("cal1_len", n, 484);
    chk("cal1_short", short_ok, 1);
    chk("cal1_trim", trim, pk(37, 0, 63, 32));
    chk("cal1_busy", cal_busy, 0);
    chk("cal1_shortoff", cal_short, 0);
    tick(); tick(); tick();
    chk("done_level", cal_done, 1);
    chk("done_dout", dout, 4'b1111);

    mode = 2; noise_ones = 8;
    run_cal("noise8");
    chk("noise8_trim", trim, pk(63, 0, 63, 32));
    noise_ones = 7;
    run_cal("noise7");
    chk("noise7_trim", trim, pk(0, 0, 63, 32));

    // Reset in the middle of channel 2, then a clean calibration.
    mode = 1;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int i = 0; i < 247; i++) tick();
    chk("midcal_ch", cal_ch, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_trim", trim, pk(32, 32, 32, 32));
    chk("midrst_busy", cal_busy, 0);
    chk("midrst_short", cal_short, 0);
    chk("midrst_done", cal_done, 0);
    chk("midrst_ch", cal_ch, 0);
    run_cal("recal");
    chk("recal_trim", trim, pk(37, 0, 63, 32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
